// File: rtl/signed_alu_pipe.sv
// ============================================================================
// Module   : signed_alu_pipe
// Brief    : Pipelined signed ADD/SUB/MUL/MAC ALU with valid/ready flow
//            control and per-result overflow/underflow flags.
//            Define ALU_SATURATE_EN to saturate results instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_alu_pipe #(
  parameter int N   = 16,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ov,
  output logic         uv,
  output logic [N-1:0] acc
);

  localparam int W = 2*N + 1;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_MAC = 2'b11;

  localparam logic signed [W-1:0] c_MAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] c_MIN = {{(N+2){1'b1}}, {(N-1){1'b0}}};

  logic                vld_q [LAT];
  logic [N-1:0]        res_q [LAT];
  logic                ov_q  [LAT];
  logic                uv_q  [LAT];
  logic [N-1:0]        acc_q;
  logic [N-1:0]        acc_d;

  logic signed [W-1:0] w_a_x;
  logic signed [W-1:0] w_b_x;
  logic signed [W-1:0] w_acc_x;
  logic signed [W-1:0] w_full;
  logic                w_ov;
  logic                w_uv;
  logic [N-1:0]        w_clip;
  logic                w_stall;
  logic                w_accept;

  assign w_stall  = vld_q[LAT-1] && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall;

  // Everything is evaluated in 2N+1 bits, wide enough for any MAC result.
  assign w_a_x   = {{(N+1){a[N-1]}}, a};
  assign w_b_x   = {{(N+1){b[N-1]}}, b};
  assign w_acc_x = acc_clr ? '0 : {{(N+1){acc_q[N-1]}}, acc_q};

  always_comb begin
    w_full = '0;
    case (op)
      c_OP_ADD: w_full = w_a_x + w_b_x;
      c_OP_SUB: w_full = w_a_x - w_b_x;
      c_OP_MUL: w_full = w_a_x * w_b_x;
      c_OP_MAC: w_full = w_acc_x + w_a_x * w_b_x;
      default:  w_full = '0;
    endcase
  end

  assign w_ov = (w_full > c_MAX);
  assign w_uv = (w_full < c_MIN);

`ifdef ALU_SATURATE_EN
  assign w_clip = w_ov ? c_MAX[N-1:0] : (w_uv ? c_MIN[N-1:0] : w_full[N-1:0]);
`else
  assign w_clip = w_full[N-1:0];
`endif

  // The accumulator moves at acceptance so back-to-back MACs chain directly.
  always_comb begin
    acc_d = acc_q;
    if (w_accept && (op == c_OP_MAC)) begin
      acc_d = w_clip;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        vld_q[k] <= 1'b0;
        res_q[k] <= '0;
        ov_q[k]  <= 1'b0;
        uv_q[k]  <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = LAT-1; k > 0; k--) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
        ov_q[k]  <= ov_q[k-1];
        uv_q[k]  <= uv_q[k-1];
      end
      vld_q[0] <= w_accept;
      if (w_accept) begin
        res_q[0] <= w_clip;
        ov_q[0]  <= w_ov;
        uv_q[0]  <= w_uv;
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign result    = res_q[LAT-1];
  assign ov        = ov_q[LAT-1];
  assign uv        = uv_q[LAT-1];
  assign acc       = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_signed_alu_pipe.sv
// ============================================================================
// Module   : tb_signed_alu_pipe
// Brief    : Scoreboard bench for signed_alu_pipe (N=16, LAT=2); honours
//            ALU_SATURATE_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_alu_pipe;

  localparam int N   = 16;
  localparam int LAT = 2;

  localparam logic [1:0] c_ADD = 2'b00;
  localparam logic [1:0] c_SUB = 2'b01;
  localparam logic [1:0] c_MUL = 2'b10;
  localparam logic [1:0] c_MAC = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         ov;
  logic         uv;
  logic [N-1:0] acc;

  signed_alu_pipe #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ov        (ov),
    .uv        (uv),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] r;
    logic         o;
    logic         u;
    int           acyc;
    int           s0;
  } exp_t;

  exp_t         sb_q [$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           stall_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [N-1:0] p_res;
  logic         p_ov;
  logic         p_uv;
  logic [N-1:0] m_acc = '0;
  logic         end_req = 1'b0;
  logic         hang_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: true signed value from plain integer arithmetic.
  function automatic void model(input logic [1:0] mop, input logic [N-1:0] ma,
                                input logic [N-1:0] mb, input logic [N-1:0] macc,
                                output logic [N-1:0] r, output logic o, output logic u);
    longint av, bv, cv, full, maxv, minv;
    av   = longint'($signed(ma));
    bv   = longint'($signed(mb));
    cv   = longint'($signed(macc));
    maxv = (longint'(1) <<< (N-1)) - 1;
    minv = -(longint'(1) <<< (N-1));
    case (mop)
      c_ADD:   full = av + bv;
      c_SUB:   full = av - bv;
      c_MUL:   full = av * bv;
      default: full = cv + av * bv;
    endcase
    o = (full > maxv);
    u = (full < minv);
    r = full[N-1:0];
`ifdef ALU_SATURATE_EN
    if (o) r = maxv[N-1:0];
    if (u) r = minv[N-1:0];
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor and model share one process, evaluated mid-cycle when all
  // signals for the upcoming edge are settled.
  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] r;
    logic         o, u;
    if (!rst_n) begin
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_result", longint'(result), 0);
      chk("rst_ov", longint'(ov), 0);
      chk("rst_uv", longint'(uv), 0);
      chk("rst_acc", longint'(acc), 0);
      sb_q.delete();
      m_acc      = '0;
      stall_prev = 1'b0;
    end else begin
      chk("acc", longint'(acc), longint'(m_acc));
      chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (stall_prev) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_result", longint'(result), longint'(p_res));
        chk("hold_ov", longint'(ov), longint'(p_ov));
        chk("hold_uv", longint'(uv), longint'(p_uv));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_output: got result %0h required no output (cycle %0d)", result, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("result", longint'(result), longint'(e.r));
          chk("ov", longint'(ov), longint'(e.o));
          chk("uv", longint'(uv), longint'(e.u));
          chk("latency", longint'(cyc), longint'(e.acyc + LAT + (stall_cnt - e.s0)));
        end
      end
      if (in_valid && in_ready) begin
        model(op, a, b, acc_clr ? '0 : m_acc, r, o, u);
        sb_q.push_back('{r: r, o: o, u: u, acyc: cyc, s0: stall_cnt});
        if (op == c_MAC) m_acc = r;
        else if (acc_clr) m_acc = '0;
      end else if (acc_clr) begin
        m_acc = '0;
      end
      stall_prev = out_valid && !out_ready;
      p_res = result;
      p_ov  = ov;
      p_uv  = uv;
      if (stall_prev) stall_cnt++;
    end
    if (end_req) begin
      if (hang_flag) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout: got no progress required completion within bound");
      end
      chk("sb_empty_at_end", longint'(sb_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  task automatic issue(input logic [1:0] t_op, input logic [N-1:0] t_a,
                       input logic [N-1:0] t_b, input logic t_clr);
    int n;
    in_valid = 1'b1;
    op       = t_op;
    a        = t_a;
    b        = t_b;
    acc_clr  = t_clr;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) hang_flag = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic clr_pulse();
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    @(posedge clk);
    #1;
    acc_clr  = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) hang_flag = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {1'b0, {(N-1){1'b1}}};
      1:       v = {1'b1, {(N-1){1'b0}}};
      2:       v = '0;
      3:       v = '1;
      4:       v = N'($urandom_range(0, 15)) - N'(8);
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = c_ADD;
    a         = '0;
    b         = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(c_ADD, 16'h7FFF, 16'h0001, 1'b0);
    issue(c_SUB, 16'h8000, 16'h0001, 1'b0);
    issue(c_MUL, 16'd300, 16'd200, 1'b0);
    issue(c_MUL, -16'sd3, 16'd7, 1'b0);
    drain();

    clr_pulse();
    issue(c_MAC, 16'd3, 16'd4, 1'b0);
    issue(c_MAC, 16'd5, 16'd6, 1'b0);
    issue(c_ADD, 16'd10, 16'd20, 1'b0);
    issue(c_MAC, 16'd2, 16'd2, 1'b1);
    drain();

    fork
      begin
        for (int i = 1; i <= 6; i++) issue(c_ADD, N'(i), N'(i), 1'b0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    clr_pulse();
    issue(c_MAC, 16'd3, 16'd4, 1'b0);
    issue(c_MAC, 16'd5, 16'd6, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(c_ADD, 16'd1, 16'd1, 1'b0);
    drain();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      a         = pick();
      b         = pick();
      acc_clr   = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    drain();

    end_req = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
